mem_ctrl: RTL and testbench

- Sequences the CPU's single byte-wide memory port (RAM plus the HCI IO window) for two requesters: instruction fetch (IF) and load/store unit (LSU).
- Arbitrates between IF and LSU, then splits each 1/2/4-byte access into byte beats. The RAM has a one-cycle synchronous read, so read data for an address issued in cycle N is captured in cycle N+1.
- Honours the top-level pause signal (rdy_in).
- Sits inside cpu, between the IF/LSU stages and the mem_* ports.

---
 rtl/mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store onto the single byte-wide memory port.
// Optional macro MEM_CTRL_RR_EN enables round-robin arbitration (default: fixed LSU-over-IF).

module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_len,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic [31:0]           ls_rdata,
  output logic                  ls_done,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state_reg;
  logic                  is_ls_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [2:0]            cnt_reg;
  logic [2:0]            beat_reg;
  logic [2:0]            cap_reg;
  logic                  issued_reg;
  logic [31:0]           buf_reg;
  logic                  mem_wr_reg;

  logic                  grant_ls;
  logic                  accept;
  logic [2:0]            req_cnt;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [2:0]            beat_inc;
  logic [1:0]            nb;
  logic                  beat_last;
  logic                  rd_complete;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           cap_word;

`ifdef MEM_CTRL_RR_EN
  // 1 = LSU won the last grant; starts at 1 so that IF wins the first tie after reset.
  logic last_ls_reg;
  assign grant_ls = ls_req && (!if_req || !last_ls_reg);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_ls_reg <= 1'b1;
    end else if (accept) begin
      last_ls_reg <= grant_ls;
    end
  end
`else
  assign grant_ls = ls_req;
`endif

  assign accept   = (state_reg == IDLE) && rdy_in && (if_req || ls_req) && !if_done && !ls_done;
  assign req_cnt  = !grant_ls ? 3'd4 : (ls_len == 2'd0) ? 3'd1 : (ls_len == 2'd1) ? 3'd2 : 3'd4;
  assign acc_addr = grant_ls ? ls_addr : if_addr;

  assign beat_inc  = beat_reg + 3'd1;
  assign nb        = beat_inc[1:0];
  assign beat_last = (beat_inc == cnt_reg);
  assign next_addr = addr_reg + ADDR_WIDTH'(beat_inc);

  // A byte is captured exactly one cycle after a beat was issued with the bus owned,
  // even if rdy_in has dropped in the capture cycle: the RAM output still belongs to us then.
  assign rd_complete = issued_reg ? (cap_reg + 3'd1 == cnt_reg) : (cap_reg == cnt_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign cap_word[8*gi +: 8] = (issued_reg && cap_reg == 3'(gi)) ? mem_din : buf_reg[8*gi +: 8];
    end
  endgenerate

  // While paused the HCI owns the bus, so no write strobe may escape.
  assign mem_wr = mem_wr_reg & rdy_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg  <= IDLE;
      is_ls_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      cnt_reg    <= '0;
      beat_reg   <= '0;
      cap_reg    <= '0;
      issued_reg <= 1'b0;
      buf_reg    <= '0;
      mem_wr_reg <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      if_data    <= '0;
      if_done    <= 1'b0;
      ls_rdata   <= '0;
      ls_done    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            is_ls_reg  <= grant_ls;
            addr_reg   <= acc_addr;
            wdata_reg  <= ls_wdata;
            cnt_reg    <= req_cnt;
            beat_reg   <= '0;
            cap_reg    <= '0;
            issued_reg <= 1'b0;
            buf_reg    <= '0;
            mem_a      <= acc_addr;
            if (grant_ls && ls_wr) begin
              state_reg  <= WR;
              mem_wr_reg <= 1'b1;
              mem_dout   <= ls_wdata[7:0];
            end else begin
              state_reg <= RD;
            end
          end
        end

        RD: begin
          if (issued_reg) begin
            buf_reg <= cap_word;
            cap_reg <= cap_reg + 3'd1;
          end
          issued_reg <= rdy_in && (beat_reg < cnt_reg);
          if (rdy_in) begin
            if (beat_reg < cnt_reg) begin
              beat_reg <= beat_inc;
              if (!beat_last) begin
                mem_a <= next_addr;
              end
            end
            if (rd_complete) begin
              state_reg <= DONE;
              mem_a     <= '0;
              if (is_ls_reg) begin
                ls_done  <= 1'b1;
                ls_rdata <= cap_word;
              end else begin
                if_done <= 1'b1;
                if_data <= cap_word;
              end
            end
          end
        end

        WR: begin
          if (rdy_in) begin
            if (beat_last) begin
              state_reg  <= DONE;
              mem_wr_reg <= 1'b0;
              mem_a      <= '0;
              mem_dout   <= '0;
              ls_done    <= 1'b1;
            end else begin
              beat_reg <= beat_inc;
              mem_a    <= next_addr;
              mem_dout <= wdata_reg[{nb, 3'b000} +: 8];
            end
          end
        end

        DONE: begin
          if (rdy_in) begin
            state_reg <= IDLE;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised self-checking bench for mem_ctrl: byte RAM model with one-cycle read,
// HCI garbage on mem_din while paused, and a byte-array reference memory.

module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_len;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_data (if_data),
    .if_done (if_done),
    .ls_req  (ls_req),
    .ls_wr   (ls_wr),
    .ls_len  (ls_len),
    .ls_addr (ls_addr),
    .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata),
    .ls_done (ls_done),
    .mem_din (mem_din),
    .mem_dout(mem_dout),
    .mem_a   (mem_a),
    .mem_wr  (mem_wr)
  );

  // Memory environment: 4 KiB aliased RAM, synchronous read, garbage when the CPU did not own the bus.
  logic [7:0]  mem [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        bd_we = 1'b0;
  logic [31:0] bd_a = '0;
  logic [7:0]  bd_d = '0;

  always @(posedge clk_in) begin
    if (bd_we) mem[bd_a[11:0]] <= bd_d;
    else if (mem_wr) mem[mem_a[11:0]] <= mem_dout;
    mem_din <= rdy_in ? mem[mem_a[11:0]] : 8'($urandom);
  end

  function automatic logic [7:0] peek(input logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(posedge clk_in); #1;
    bd_we = 1'b0;
    ref_mem[a[11:0]] = d;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v;
    logic [31:0] ai;
    v = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v = v | (32'(ref_mem[ai[11:0]]) << (8 * i));
    end
    return v;
  endfunction

  logic [31:0] trace_a [0:63];
  logic        trace_wr [0:63];
  logic [7:0]  trace_d [0:63];

  // Drives one request from cycle 0 (the current cycle), pauses the bus in cycles ps..pe,
  // records the port trace and returns in the cycle after done with req dropped.
  task automatic run_op(input bit is_ls, input bit wr, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ps, input int pe,
                        output int done_cyc, output logic [31:0] data, output int wr_in_pause);
    bit seen;
    seen = 0; done_cyc = -1; data = '0; wr_in_pause = 0;
    if (is_ls) begin
      ls_req = 1'b1; ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < 60; c++) begin
      rdy_in = !(c >= ps && c <= pe);
      @(negedge clk_in);
      trace_a[c] = mem_a; trace_wr[c] = mem_wr; trace_d[c] = mem_dout;
      if (!rdy_in && mem_wr) wr_in_pause++;
      if ((is_ls ? ls_done : if_done) && !seen) begin
        seen = 1; done_cyc = c; data = is_ls ? ls_rdata : if_data;
      end
      @(posedge clk_in); #1;
      if (seen) break;
    end
    if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
    rdy_in = 1'b1;
    $display("txn %s wr=%0d len=%0d addr=%h wdata=%h done_cycle=%0d data=%h",
             is_ls ? "LSU" : "IF ", wr, len, addr, wdata, done_cyc, data);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    if_addr = '0; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin failures++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    checks++; if (if_data !== 32'h0) begin failures++; $display("FAIL reset_if_data got=%h exp=0", if_data); end
    checks++; if (ls_rdata !== 32'h0) begin failures++; $display("FAIL reset_ls_rdata got=%h exp=0", ls_rdata); end
    checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL reset_if_done got=%b exp=0", if_done); end
    checks++; if (ls_done !== 1'b0) begin failures++; $display("FAIL reset_ls_done got=%b exp=0", ls_done); end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_fetch_word();
    int dc, wp;
    logic [31:0] d;
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    run_op(0, 0, 2'd2, 32'h100, 32'h0, -1, -1, dc, d, wp);
    checks++; if (dc !== 6) begin failures++; $display("FAIL fetch_done_cycle got=%0d exp=6", dc); end
    checks++; if (d !== 32'h00100513) begin failures++; $display("FAIL fetch_data got=%h exp=00100513", d); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (trace_a[i+1] !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL fetch_addr cycle=%0d got=%h exp=%h", i + 1, trace_a[i+1], 32'h100 + 32'(i));
      end
    end
    @(negedge clk_in);
    checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL fetch_done_width got=%b exp=0", if_done); end
    @(posedge clk_in); #1;
  endtask

  task automatic test_store_load();
    int dc, wp, nwr;
    logic [31:0] d;
    run_op(1, 1, 2'd0, 32'h20, 32'hAABBCCDD, -1, -1, dc, d, wp);
    ref_mem[12'h020] = 8'hDD;
    nwr = 0;
    for (int c = 0; c <= 2; c++) if (trace_wr[c] === 1'b1) nwr++;
    checks++; if (dc !== 2) begin failures++; $display("FAIL sb_done_cycle got=%0d exp=2", dc); end
    checks++; if (nwr !== 1) begin failures++; $display("FAIL sb_write_beats got=%0d exp=1", nwr); end
    checks++;
    if (trace_a[1] !== 32'h20 || trace_d[1] !== 8'hDD || trace_wr[1] !== 1'b1) begin
      failures++; $display("FAIL sb_beat got a=%h d=%h wr=%b exp a=00000020 d=dd wr=1", trace_a[1], trace_d[1], trace_wr[1]);
    end
    checks++; if (peek(32'h20) !== 8'hDD) begin failures++; $display("FAIL sb_mem got=%h exp=dd", peek(32'h20)); end
    poke(32'h21, 8'h7F);
    run_op(1, 0, 2'd1, 32'h20, 32'h0, -1, -1, dc, d, wp);
    checks++; if (d !== 32'h00007FDD) begin failures++; $display("FAIL lh_data got=%h exp=00007fdd", d); end
    checks++; if (dc !== 4) begin failures++; $display("FAIL lh_done_cycle got=%0d exp=4", dc); end
  endtask

  task automatic preload_region();
    for (int a = 32'h3F8; a < 32'h448; a++) poke(32'(a), 8'($urandom));
    for (int a = 0; a < 8; a++) poke(32'(a), 8'($urandom));
    for (int a = 32'hFF8; a < 32'h1000; a++) poke(32'(a), 8'($urandom));
  endtask

  task automatic test_back_to_back();
    int dc, wp;
    logic [31:0] d;
    logic [31:0] e;
    e = ref_read(32'h100, 4);
    run_op(0, 0, 2'd2, 32'h100, 32'h0, -1, -1, dc, d, wp);
    checks++; if (dc !== 6 || d !== e) begin failures++; $display("FAIL b2b_first got=%0d/%h exp=6/%h", dc, d, e); end
    e = ref_read(32'h400, 4);
    run_op(0, 0, 2'd2, 32'h400, 32'h0, -1, -1, dc, d, wp);
    checks++; if (dc !== 6 || d !== e) begin failures++; $display("FAIL b2b_second got=%0d/%h exp=6/%h", dc, d, e); end
    e = ref_read(32'h404, 4);
    run_op(1, 0, 2'd3, 32'h404, 32'h0, -1, -1, dc, d, wp);
    checks++; if (dc !== 6 || d !== e) begin failures++; $display("FAIL b2b_third got=%0d/%h exp=6/%h", dc, d, e); end
  endtask

  task automatic test_random();
    bit is_ls, wr;
    logic [1:0] len;
    logic [31:0] addr, wdata, d, e, sh, ai;
    int n, dc, wp, bad, nwr;
    for (int t = 0; t < 24; t++) begin
      is_ls = ($urandom_range(0, 3) != 0);
      wr    = is_ls && ($urandom_range(0, 1) == 1);
      len   = is_ls ? 2'($urandom_range(0, 3)) : 2'd2;
      addr  = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFD + 32'($urandom_range(0, 2))
                                          : 32'h400 + 32'($urandom_range(0, 59));
      wdata = $urandom;
      n = !is_ls ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
      e = ref_read(addr, n);
      run_op(is_ls, wr, len, addr, wdata, -1, -1, dc, d, wp);
      checks++;
      if (dc !== (wr ? n + 1 : n + 2)) begin
        failures++; $display("FAIL rand_done_cycle t=%0d got=%0d exp=%0d", t, dc, wr ? n + 1 : n + 2);
      end
      bad = 0;
      for (int i = 0; i < n; i++) begin
        sh = wdata >> (8 * i);
        if (trace_a[i+1] !== addr + 32'(i)) bad++;
        if (wr && (trace_wr[i+1] !== 1'b1 || trace_d[i+1] !== sh[7:0])) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rand_beats t=%0d got=%0d_bad exp=0_bad", t, bad); end
      if (!wr) begin
        checks++; if (d !== e) begin failures++; $display("FAIL rand_rdata t=%0d got=%h exp=%h", t, d, e); end
      end else begin
        for (int i = 0; i < n; i++) begin
          sh = wdata >> (8 * i);
          ai = addr + 32'(i);
          ref_mem[ai[11:0]] = sh[7:0];
        end
        nwr = 0;
        for (int c = 0; c <= dc && c < 64; c++) if (trace_wr[c] === 1'b1) nwr++;
        checks++; if (nwr !== n) begin failures++; $display("FAIL rand_write_beats t=%0d got=%0d exp=%0d", t, nwr, n); end
        bad = 0;
        for (int k = -1; k <= 4; k++) begin
          ai = addr + 32'(k);
          if (peek(ai) !== ref_mem[ai[11:0]]) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rand_mem t=%0d got=%0d_bad_bytes exp=0", t, bad); end
      end
    end
  endtask

  task automatic test_contention();
    int ls_dc, if_dc, exp_ls, exp_if;
    logic [31:0] if_d, e;
    e = ref_read(32'h400, 4);
`ifdef MEM_CTRL_RR_EN
    exp_if = 6; exp_ls = 12;
`else
    exp_ls = 5; exp_if = 12;
`endif
    ls_dc = -1; if_dc = -1; if_d = '0;
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd2; ls_addr = 32'h40; ls_wdata = 32'h11223344;
    if_req = 1'b1; if_addr = 32'h400;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (ls_done && ls_dc < 0) ls_dc = c;
      if (if_done && if_dc < 0) begin if_dc = c; if_d = if_data; end
      @(posedge clk_in); #1;
      if (ls_dc == c) ls_req = 1'b0;
      if (if_dc == c) if_req = 1'b0;
      if (ls_dc >= 0 && if_dc >= 0) break;
    end
    ls_req = 1'b0; if_req = 1'b0;
    $display("txn contention ls_done_cycle=%0d if_done_cycle=%0d if_data=%h", ls_dc, if_dc, if_d);
    for (int i = 0; i < 4; i++) ref_mem[12'h040 + 12'(i)] = 8'(32'h11223344 >> (8 * i));
    checks++; if (ls_dc !== exp_ls) begin failures++; $display("FAIL cont_ls_done got=%0d exp=%0d", ls_dc, exp_ls); end
    checks++; if (if_dc !== exp_if) begin failures++; $display("FAIL cont_if_done got=%0d exp=%0d", if_dc, exp_if); end
    checks++; if (if_d !== e) begin failures++; $display("FAIL cont_if_data got=%h exp=%h", if_d, e); end
    checks++;
    if ({peek(32'h43), peek(32'h42), peek(32'h41), peek(32'h40)} !== 32'h11223344) begin
      failures++; $display("FAIL cont_mem got=%h exp=11223344", {peek(32'h43), peek(32'h42), peek(32'h41), peek(32'h40)});
    end
  endtask

  task automatic test_pause_read();
    int dc, wp, bad, nwr;
    logic [31:0] d;
    poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
    run_op(1, 0, 2'd2, 32'h200, 32'h0, 3, 6, dc, d, wp);
    checks++; if (dc !== 10) begin failures++; $display("FAIL pr_done_cycle got=%0d exp=10", dc); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL pr_data got=%h exp=deadbeef", d); end
    bad = 0;
    for (int c = 3; c <= 6; c++) if (trace_a[c] !== 32'h202) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL pr_addr_frozen got=%0d_bad exp=0", bad); end
    nwr = 0;
    for (int c = 0; c <= 10; c++) if (trace_wr[c] !== 1'b0) nwr++;
    checks++; if (nwr !== 0) begin failures++; $display("FAIL pr_no_write got=%0d exp=0", nwr); end
  endtask

  task automatic test_pause_write();
    int dc, wp, bad, cnt;
    logic [31:0] d;
    run_op(1, 1, 2'd2, 32'h300, 32'hCAFEBABE, 3, 5, dc, d, wp);
    for (int i = 0; i < 4; i++) ref_mem[12'h300 + 12'(i)] = 8'(32'hCAFEBABE >> (8 * i));
    checks++; if (dc !== 8) begin failures++; $display("FAIL pw_done_cycle got=%0d exp=8", dc); end
    checks++; if (wp !== 0) begin failures++; $display("FAIL pw_wr_in_pause got=%0d exp=0", wp); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      for (int c = 0; c <= dc && c < 64; c++) if (trace_wr[c] === 1'b1 && trace_a[c] === 32'h300 + 32'(i)) cnt++;
      if (cnt != 1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL pw_once got=%0d_bad_bytes exp=0", bad); end
    checks++;
    if ({peek(32'h303), peek(32'h302), peek(32'h301), peek(32'h300)} !== 32'hCAFEBABE) begin
      failures++; $display("FAIL pw_mem got=%h exp=cafebabe", {peek(32'h303), peek(32'h302), peek(32'h301), peek(32'h300)});
    end
  endtask

  task automatic test_reset_midop();
    int dc, wp, nd;
    logic [31:0] d;
    logic [31:0] e;
    if_req = 1'b1; if_addr = 32'h100; rdy_in = 1'b1;
    repeat (3) begin @(posedge clk_in); #1; end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL rm_mem_a got=%h exp=0", mem_a); end
    checks++; if (if_data !== 32'h0) begin failures++; $display("FAIL rm_if_data got=%h exp=0", if_data); end
    checks++; if (ls_rdata !== 32'h0) begin failures++; $display("FAIL rm_ls_rdata got=%h exp=0", ls_rdata); end
    checks++;
    if ({mem_dout, mem_wr, if_done, ls_done} !== 11'h0) begin
      failures++; $display("FAIL rm_ctrl got=%h exp=0", {mem_dout, mem_wr, if_done, ls_done});
    end
    if_req = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (if_done || ls_done) nd++;
    end
    @(posedge clk_in); #1;
    checks++; if (nd !== 0) begin failures++; $display("FAIL rm_no_done got=%0d exp=0", nd); end
    e = ref_read(32'h100, 4);
    run_op(0, 0, 2'd2, 32'h100, 32'h0, -1, -1, dc, d, wp);
    checks++; if (dc !== 6 || d !== e) begin failures++; $display("FAIL rm_fresh got=%0d/%h exp=6/%h", dc, d, e); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_word();
    test_store_load();
    preload_region();
    test_back_to_back();
    test_random();
    test_contention();
    test_pause_read();
    test_pause_write();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
